// File: rtl/column_readout_ctrl_if.sv
// ---------------------------------------------------------------------------
// column_readout_ctrl_if
// Framed-word stream from the column readout controller toward the column
// FIFO. A word moves on any clk edge where outValid and outReady are both 1.
//
//   outData   [DATAWIDTH-1:0]  framed word (header / hit data / trailer)
//   outType   [1:0]            01 header, 10 data, 11 trailer
//   outValid                   outData/outType are valid
//   outReady                   downstream accepts the current word
//
// master: the controller (drives data/type/valid, samples ready)
// slave : the FIFO side   (samples data/type/valid, drives ready)
// ---------------------------------------------------------------------------
interface column_readout_ctrl_if #(
  parameter int DATAWIDTH = 46
);
  logic [DATAWIDTH-1:0] outData;
  logic [1:0]           outType;
  logic                 outValid;
  logic                 outReady;

  modport master (
    output outData,
    output outType,
    output outValid,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outType,
    input  outValid,
    output outReady
  );
endinterface

// File: rtl/column_readout_ctrl.sv
// ---------------------------------------------------------------------------
// column_readout_ctrl
// Bottom-of-column controller for the SWCell pixel chain. Builds the
// broadcast word sent up the chain, keeps the L1-buffer write/read pointers,
// accepts or drops triggers, and reads each triggered event out of the chain
// as a header / data... / trailer sequence on the framed output stream.
//
// Ports
//   clk         40 MHz clock
//   reset       synchronous, active-low reset
//   enable      allows new event readouts to start
//   L1AIn       trigger pulse from global readout
//   dnBCST      {preLoad, CBwrAddr[8:0], L1wrAddr, L1rdAddr, load, L1A, pixReset}
//   chainHits   {trigHit[3:0], unreadHit} from the first SWCell
//   chainData   data word from the first SWCell
//   chainRead   read pulse to the first SWCell
//   out         framed output stream (column_readout_ctrl_if master)
//   busy        readout FSM is not idle
//   l1Full      L1 occupancy is at its maximum (2^L1ADDRWIDTH-1)
//   droppedL1A  saturating count of triggers rejected while full
//
// BCSTWIDTH must equal 1 + 9 + 2*L1ADDRWIDTH + 3.
//
// Readout FSM
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for enable and a non-empty L1 buffer
//   PRELOAD  | preLoad broadcast for one cycle
//   LOAD     | load broadcast with L1rdAddr = event; CBwrAddr snapshot
//   SETTLE   | two cycles for the chain to propagate the loaded event
//   HEADER   | header word {L1rdAddr, CB snapshot} offered downstream
//   SAMPLE   | inspect unreadHit: offer data, start flush, or finish
//   READ     | one idle cycle after a chainRead so the chain can update
//   FLUSH    | hit limit reached: drain remaining hits, no output
//   TRAILER  | trailer word {truncated, hitCount} offered downstream
// ---------------------------------------------------------------------------
module column_readout_ctrl #(
  parameter int L1ADDRWIDTH = 7,
  parameter int BCSTWIDTH   = 27,
  parameter int DATAWIDTH   = 46,
  parameter int MAXHITS     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   L1AIn,
  output logic [BCSTWIDTH-1:0]   dnBCST,
  input  logic [4:0]             chainHits,
  input  logic [DATAWIDTH-1:0]   chainData,
  output logic                   chainRead,
  column_readout_ctrl_if.master  out,
  output logic                   busy,
  output logic                   l1Full,
  output logic [7:0]             droppedL1A
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_LOAD,
    ST_SETTLE,
    ST_HEADER,
    ST_SAMPLE,
    ST_READ,
    ST_FLUSH,
    ST_TRAILER
  } state_t;

  localparam logic [L1ADDRWIDTH-1:0] OCC_MAX       = '1;
  localparam logic [1:0]             SETTLE_CYCLES = 2'd2;
  localparam logic [4:0]             HIT_LIMIT     = 5'(MAXHITS);
  localparam logic [1:0]             TYPE_HEADER   = 2'b01;
  localparam logic [1:0]             TYPE_DATA     = 2'b10;
  localparam logic [1:0]             TYPE_TRAILER  = 2'b11;

  state_t                  state, state_nxt;

  logic [L1ADDRWIDTH-1:0]  wr_ptr, rd_ptr;
  logic [L1ADDRWIDTH-1:0]  occupancy, occ_pending;
  logic [8:0]              cb_wr_addr, cb_snap;
  logic                    l1a_bcst;
  logic                    accept_ok;
  logic                    pix_reset, pix_hold;
  logic [4:0]              hit_count;
  logic                    truncated;
  logic [1:0]              settle_cnt;
  logic                    flush_phase;
  logic                    unread;

  logic                    preload;
  logic                    load;
  logic                    hit_inc;
  logic                    evt_clr;
  logic                    trunc_set;
  logic                    snap_en;
  logic                    settle_load;
  logic                    out_valid;
  logic [1:0]              out_type;
  logic [DATAWIDTH-1:0]    out_data;

  // Only the unread-hit flag steers readout; per-trigger hit flags are
  // carried on the chain for other consumers.
  logic                    unused_trig_hits;
  assign unused_trig_hits = ^chainHits[4:1];

  assign unread    = chainHits[0];
  assign occupancy = wr_ptr - rd_ptr;
  assign l1Full    = (occupancy == OCC_MAX);

  // wr_ptr advances one cycle after the broadcast, so a trigger accepted in
  // the previous cycle is still counted here; otherwise a back-to-back
  // trigger burst could push occupancy past its maximum.
  assign occ_pending = occupancy + L1ADDRWIDTH'(l1a_bcst);
  assign accept_ok   = (occ_pending != OCC_MAX);

  assign busy = (state != ST_IDLE);

  assign dnBCST = {preload, cb_wr_addr, wr_ptr, rd_ptr, load, l1a_bcst, pix_reset};

  assign out.outValid = out_valid;
  assign out.outType  = out_type;
  assign out.outData  = out_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cb_wr_addr  <= '0;
      cb_snap     <= '0;
      l1a_bcst    <= 1'b0;
      droppedL1A  <= '0;
      pix_reset   <= 1'b1;
      pix_hold    <= 1'b1;
      hit_count   <= '0;
      truncated   <= 1'b0;
      settle_cnt  <= '0;
      flush_phase <= 1'b0;
    end else begin
      state      <= state_nxt;
      cb_wr_addr <= cb_wr_addr + 9'd1;

      // pix_hold stretches pixReset through the first cycle after release.
      pix_hold  <= 1'b0;
      pix_reset <= pix_hold;

      l1a_bcst <= L1AIn && accept_ok;
      if (L1AIn && !accept_ok && (droppedL1A != 8'hFF)) begin
        droppedL1A <= droppedL1A + 8'd1;
      end
      if (l1a_bcst) begin
        wr_ptr <= wr_ptr + L1ADDRWIDTH'(1);
      end

      if (evt_clr) begin
        rd_ptr <= rd_ptr + L1ADDRWIDTH'(1);
      end

      if (snap_en) begin
        cb_snap <= cb_wr_addr;
      end

      if (evt_clr) begin
        hit_count <= '0;
      end else if (hit_inc) begin
        hit_count <= hit_count + 5'd1;
      end

      if (evt_clr) begin
        truncated <= 1'b0;
      end else if (trunc_set) begin
        truncated <= 1'b1;
      end

      if (settle_load) begin
        settle_cnt <= SETTLE_CYCLES - 2'd1;
      end else if (settle_cnt != 2'd0) begin
        settle_cnt <= settle_cnt - 2'd1;
      end

      // Flush reads go out on every other cycle, starting with the first
      // FLUSH cycle, so the chain gets a cycle to shift between reads.
      flush_phase <= (state == ST_FLUSH) ? ~flush_phase : 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    preload     = 1'b0;
    load        = 1'b0;
    chainRead   = 1'b0;
    hit_inc     = 1'b0;
    evt_clr     = 1'b0;
    trunc_set   = 1'b0;
    snap_en     = 1'b0;
    settle_load = 1'b0;
    out_valid   = 1'b0;
    out_type    = 2'b00;
    out_data    = '0;

    case (state)
      ST_IDLE: begin
        if (enable && (occupancy != '0)) begin
          state_nxt = ST_PRELOAD;
        end
      end

      ST_PRELOAD: begin
        preload   = 1'b1;
        state_nxt = ST_LOAD;
      end

      ST_LOAD: begin
        load        = 1'b1;
        snap_en     = 1'b1;
        settle_load = 1'b1;
        state_nxt   = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt == 2'd0) begin
          state_nxt = ST_HEADER;
        end
      end

      ST_HEADER: begin
        out_valid                   = 1'b1;
        out_type                    = TYPE_HEADER;
        out_data[L1ADDRWIDTH+8:0]   = {rd_ptr, cb_snap};
        if (out.outReady) begin
          state_nxt = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (!unread) begin
          state_nxt = ST_TRAILER;
        end else if (hit_count == HIT_LIMIT) begin
          trunc_set = 1'b1;
          state_nxt = ST_FLUSH;
        end else begin
          out_valid = 1'b1;
          out_type  = TYPE_DATA;
          out_data  = chainData;
          // The chain only advances on chainRead, so chainData holds while
          // the word is stalled downstream.
          if (out.outReady) begin
            hit_inc   = 1'b1;
            chainRead = 1'b1;
            state_nxt = ST_READ;
          end
        end
      end

      ST_READ: begin
        state_nxt = ST_SAMPLE;
      end

      ST_FLUSH: begin
        if (!unread) begin
          state_nxt = ST_TRAILER;
        end else begin
          chainRead = !flush_phase;
        end
      end

      ST_TRAILER: begin
        out_valid     = 1'b1;
        out_type      = TYPE_TRAILER;
        out_data[5:0] = {truncated, hit_count};
        if (out.outReady) begin
          evt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_column_readout_ctrl.sv
module tb_column_readout_ctrl;

  localparam int L1W  = 7;
  localparam int BW   = 27;
  localparam int DW   = 46;
  localparam int MAXH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          l1a_in = 1'b0;
  logic [BW-1:0] dn_bcst;
  logic [4:0]    chain_hits;
  logic [DW-1:0] chain_data;
  logic          chain_read;
  logic          busy;
  logic          l1_full;
  logic [7:0]    dropped;

  column_readout_ctrl_if #(.DATAWIDTH(DW)) out_if ();

  column_readout_ctrl #(
    .L1ADDRWIDTH(L1W),
    .BCSTWIDTH  (BW),
    .DATAWIDTH  (DW),
    .MAXHITS    (MAXH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .L1AIn     (l1a_in),
    .dnBCST    (dn_bcst),
    .chainHits (chain_hits),
    .chainData (chain_data),
    .chainRead (chain_read),
    .out       (out_if),
    .busy      (busy),
    .l1Full    (l1_full),
    .droppedL1A(dropped)
  );

  always #5 clk = ~clk;

  // Reference free-running CB counter.
  logic [8:0] cb_model = '0;
  always @(posedge clk) cb_model <= reset ? cb_model + 9'd1 : 9'd0;

  // Chain model: an armed event exposes arm_hits words, one consumed per read.
  int unsigned rd_total = 0;
  int unsigned arm_base = 0;
  int unsigned arm_hits = 0;
  logic [7:0]  arm_tag  = '0;
  int unsigned chain_idx;

  always @(posedge clk) if (chain_read) rd_total <= rd_total + 1;

  function automatic logic [DW-1:0] word(logic [7:0] tag, int unsigned i);
    logic [31:0] iv;
    iv = i;
    return {22'b0, tag, iv[15:0]};
  endfunction

  assign chain_idx  = rd_total - arm_base;
  assign chain_hits = {4'b0000, (chain_idx < arm_hits)};
  assign chain_data = word(arm_tag, chain_idx);

  typedef struct {
    logic           hdr;
    logic [1:0]     typ;
    logic [DW-1:0]  data;
    logic [L1W-1:0] rd;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       rst;
    logic       l1a;
    logic       pix;
    logic       bc_l1a;
    logic [6:0] wr;
    logic [8:0] cb;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_reads = 0;
  int         n_flush_reads = 0;
  int         n_l1a = 0;
  logic [8:0] cb_at_load = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    l1a_in = 1'b0;
    step(3);
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic arm(logic [7:0] tag, int unsigned hits);
    arm_base = rd_total;
    arm_hits = hits;
    arm_tag  = tag;
  endtask

  task automatic push_hdr(logic [L1W-1:0] rd);
    exp_t e;
    e.hdr = 1'b1; e.typ = 2'b01; e.data = '0; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic push_event(logic [L1W-1:0] rd, logic [7:0] tag, int unsigned hits);
    exp_t        e;
    int unsigned nd;
    logic [5:0]  tr;
    nd = (hits > MAXH) ? MAXH : hits;
    push_hdr(rd);
    for (int unsigned i = 0; i < nd; i++) begin
      e.hdr = 1'b0; e.typ = 2'b10; e.data = word(tag, i); e.rd = '0;
      sb.push_back(e);
    end
    tr = {(hits > MAXH), 5'(nd)};
    e.hdr = 1'b0; e.typ = 2'b11; e.data = DW'(tr); e.rd = '0;
    sb.push_back(e);
  endtask

  // Waits for the FSM to leave and then return to IDLE, both bounded.
  task automatic run_event(int budget);
    int i;
    i = 0;
    while (!busy && i < 20) begin step(1); i++; end
    chk("event_start", busy, 1'b1);
    i = 0;
    while (busy && i < budget) begin step(1); i++; end
    chk("event_end", busy, 1'b0);
  endtask

  task automatic monitor();
    logic          prev_stall, prev_read, prev_pre;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_type;
    exp_t          e;
    logic [DW-1:0] ed;
    prev_stall = 1'b0; prev_read = 1'b0; prev_pre = 1'b0;
    prev_data = '0; prev_type = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0; prev_read = 1'b0; prev_pre = 1'b0;
      end else begin
        chk("cb_wr_addr", dn_bcst[25:17], cb_model);
        if (prev_pre)  chk("load_after_preload", dn_bcst[2], 1'b1);
        if (prev_read) chk("gap_after_read", out_if.outValid, 1'b0);
        if (prev_stall)
          chk("stall_hold", {out_if.outValid, out_if.outType, out_if.outData},
              {1'b1, prev_type, prev_data});
        if (dn_bcst[2]) cb_at_load = cb_model;
        if (out_if.outValid && out_if.outReady) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got type %0b data 0x%0h expected no word",
                     out_if.outType, out_if.outData);
          end else begin
            e  = sb.pop_front();
            ed = e.hdr ? DW'({e.rd, cb_at_load}) : e.data;
            chk("out_word", {out_if.outType, out_if.outData}, {e.typ, ed});
          end
        end
        if (chain_read) begin
          n_reads++;
          if (!(out_if.outValid && out_if.outReady)) n_flush_reads++;
        end
        if (dn_bcst[1]) n_l1a++;
        prev_stall = out_if.outValid && !out_if.outReady;
        prev_data  = out_if.outData;
        prev_type  = out_if.outType;
        prev_read  = chain_read;
        prev_pre   = dn_bcst[26];
      end
    end
  endtask

  initial begin
    vec_t tbl[11];
    bit   found;
    int   r0, f0, l0;

    //           rst   l1a   pix   L1A   wr     cb
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 9'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 9'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 9'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 9'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 9'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 7'd0, 9'd3};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 9'd4};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 7'd1, 9'd5};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 7'd2, 9'd6};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 9'd7};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd3, 9'd8};

    out_if.outReady = 1'b1;
    enable          = 1'b0;
    fork
      monitor();
    join_none

    // Reset, pixReset stretch, CB count and trigger accept (enable=0).
    for (int i = 0; i < 11; i++) begin
      reset  = tbl[i].rst;
      l1a_in = tbl[i].l1a;
      step(1);
      chk($sformatf("vec%0d", i),
          {dn_bcst[0], dn_bcst[1], dn_bcst[16:10], dn_bcst[25:17], busy},
          {tbl[i].pix, tbl[i].bc_l1a, tbl[i].wr, tbl[i].cb, 1'b0});
      if (i == 2)
        chk("reset_outputs",
            {out_if.outValid, out_if.outType, out_if.outData, chain_read,
             dn_bcst[26], dn_bcst[2], dn_bcst[9:3], dropped, l1_full}, '0);
    end
    step(503);
    chk("cb_pre_wrap", dn_bcst[25:17], 9'd511);
    step(1);
    chk("cb_wrap", dn_bcst[25:17], 9'd0);

    // Single event with 3 hits.
    do_reset();
    enable = 1'b1;
    arm(8'hA1, 3);
    push_event('0, 8'hA1, 3);
    r0 = n_reads;
    l1a_in = 1'b1;
    step(1);
    l1a_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (dn_bcst[26]) found = 1'b1;
    end
    chk("preload_seen", found, 1'b1);
    step(1);
    chk("load_rd", {dn_bcst[2], dn_bcst[9:3]}, {1'b1, 7'd0});
    run_event(400);
    chk("rd_after_3", dn_bcst[9:3], 7'd1);
    chk("reads_3", n_reads - r0, 3);
    chk("sb_empty_3", sb.size(), 0);

    // 20-hit event: 16 forwarded, 4 flushed, truncated trailer.
    do_reset();
    enable = 1'b1;
    arm(8'hC3, 20);
    push_event('0, 8'hC3, 20);
    r0 = n_reads;
    f0 = n_flush_reads;
    l1a_in = 1'b1;
    step(1);
    l1a_in = 1'b0;
    run_event(600);
    chk("reads_20", n_reads - r0, 20);
    chk("flush_reads", n_flush_reads - f0, 4);
    chk("chain_drained", chain_idx, 20);
    chk("rd_after_20", dn_bcst[9:3], 7'd1);
    chk("sb_empty_20", sb.size(), 0);

    // Fill the L1 buffer with readout disabled, then overflow it.
    do_reset();
    enable = 1'b0;
    l0 = n_l1a;
    l1a_in = 1'b1;
    step(127);
    l1a_in = 1'b0;
    step(3);
    chk("l1_full", {l1_full, dn_bcst[16:10]}, {1'b1, 7'd127});
    chk("l1a_127", n_l1a - l0, 127);
    chk("no_drop_yet", dropped, 8'd0);
    for (int i = 0; i < 3; i++) begin
      l1a_in = 1'b1;
      step(1);
      l1a_in = 1'b0;
      step(2);
    end
    chk("dropped_3", dropped, 8'd3);
    chk("wr_held", {l1_full, dn_bcst[16:10]}, {1'b1, 7'd127});
    chk("no_extra_l1a", n_l1a - l0, 127);

    // 5-hit event with random back-pressure.
    do_reset();
    enable = 1'b1;
    arm(8'h5E, 5);
    push_event('0, 8'h5E, 5);
    r0 = n_reads;
    l1a_in = 1'b1;
    step(1);
    l1a_in = 1'b0;
    begin
      bit seen_busy, done;
      seen_busy = 1'b0;
      done      = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
        out_if.outReady = 1'($urandom_range(0, 1));
        step(1);
        if (busy) seen_busy = 1'b1;
        else if (seen_busy) done = 1'b1;
      end
      chk("rand_event_done", done, 1'b1);
    end
    chk("reads_5", n_reads - r0, 5);
    chk("sb_empty_5", sb.size(), 0);
    chk("rd_after_5", dn_bcst[9:3], 7'd1);

    // Reset while a data word is stalled in SAMPLE.
    out_if.outReady = 1'b0;
    arm(8'h7B, 5);
    push_hdr(7'd1);
    l1a_in = 1'b1;
    step(1);
    l1a_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (out_if.outValid && out_if.outType == 2'b01) found = 1'b1;
    end
    chk("hdr_offered", found, 1'b1);
    out_if.outReady = 1'b1;
    step(1);
    out_if.outReady = 1'b0;
    chk("in_sample", {out_if.outValid, out_if.outType, busy}, {1'b1, 2'b10, 1'b1});
    reset = 1'b0;
    step(1);
    chk("abandon",
        {out_if.outValid, busy, dn_bcst[16:10], dn_bcst[9:3], dn_bcst[0], chain_read},
        {1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0});
    reset = 1'b1;
    out_if.outReady = 1'b1;
    step(4);
    chk("quiet_after_reset", {out_if.outValid, busy, dn_bcst[0]}, 3'b000);
    chk("sb_empty_abandon", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/column_readout_ctrl.md
Name: column_readout_ctrl

Overview:
- Bottom-of-column controller for the SWCell pixel chain.
- Owns every broadcast-word field sent up the chain: reset, L1A, load, L1rdAddr, L1wrAddr, CBwrAddr and preLoad.
- Keeps the L1-buffer write and read pointers, and sequences event readout by loading each triggered event and draining hits with read pulses.
- Frames each event as header / data / trailer words on a valid/ready output toward the column FIFO.

Parameters:
- L1ADDRWIDTH, 7, L1-buffer pointer width (depth 2^L1ADDRWIDTH).
- BCSTWIDTH, 27, broadcast word width; must equal 1+9+2*L1ADDRWIDTH+3.
- DATAWIDTH, 46, chain data word width.
- MAXHITS, 16, maximum hit words forwarded per event.

Ports:
- clk  in  1  40 MHz clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  allows new event readouts.
- L1AIn  in  1  trigger pulse from global readout.
- dnBCST  out  BCSTWIDTH  {preLoad, CBwrAddr[8:0], L1wrAddr, L1rdAddr, load, L1A, pixReset}.
- chainHits  in  5  {trigHit[3:0], unreadHit} from the first SWCell.
- chainData  in  DATAWIDTH  data word from the first SWCell.
- chainRead  out  1  read pulse to the first SWCell.
- outData  out  DATAWIDTH  framed word.
- outType  out  2  word type: 01 header, 10 data, 11 trailer.
- outValid  out  1  outData/outType valid.
- outReady  in  1  downstream accepts.
- busy  out  1  FSM not in IDLE.
- l1Full  out  1  L1 occupancy equals 2^L1ADDRWIDTH-1.
- droppedL1A  out  8  saturating count of rejected triggers.

Behaviour:
- Reset (reset=0 at a clk edge):
  - FSM goes to IDLE.
  - Pointers, CBwrAddr, droppedL1A and hit count clear to 0.
  - chainRead, outValid, preLoad, load and L1A go to 0; outData/outType go to 0.
  - pixReset=1 while reset=0 and for 1 cycle after release, then 0.
  - A reset mid-event abandons the event immediately; no trailer is emitted.
- CBwrAddr: 9-bit free-running, +1 every cycle, wraps 511→0.
- Occupancy = (L1wrAddr − L1rdAddr) mod 2^L1ADDRWIDTH.
- Trigger accept:
  - An L1AIn cycle with l1Full=0 registers broadcast L1A=1 for exactly 1 cycle (1-cycle latency).
  - L1wrAddr increments on the cycle after the broadcast L1A.
  - If l1Full=1, no broadcast is made and droppedL1A increments, saturating at 255.
  - Accept runs independently of the FSM, so L1A and load may be high in the same cycle.
- FSM states: IDLE, PRELOAD, LOAD, SETTLE, HEADER, SAMPLE, READ, FLUSH, TRAILER.
  - IDLE: go to PRELOAD when enable=1 and occupancy≠0.
  - PRELOAD: preLoad=1 for 1 cycle, then LOAD.
  - LOAD: load=1 for 1 cycle, with L1rdAddr equal to the event's address. Snapshot CBwrAddr. Go to SETTLE.
  - SETTLE: wait 2 cycles for chain propagation, then HEADER.
  - HEADER: outValid=1, outType=01, outData[L1ADDRWIDTH+8:0]={L1rdAddr, CBsnapshot}, other bits 0. On accept go to SAMPLE.
  - SAMPLE:
    - chainHits[0]=0 → TRAILER.
    - chainHits[0]=1 and hitCount=MAXHITS → FLUSH, set truncated.
    - Otherwise outValid=1, outType=10, outData=chainData unmodified. On accept: hitCount+1, chainRead=1 for 1 cycle, go to READ.
  - READ: 1-cycle gap with outValid=0, then SAMPLE. This lets the chain update.
  - FLUSH: chainRead=1 on alternate cycles with no output while chainHits[0]=1. When chainHits[0]=0 go to TRAILER.
  - TRAILER: outValid=1, outType=11, outData[5:0]={truncated, hitCount[4:0]}, other bits 0. On accept, L1rdAddr+1, clear hitCount and truncated, go to IDLE.
- Output handshake:
  - Once outValid=1, outData and outType stay stable until outValid&outReady.
  - outValid never drops without an accept, except on reset.
- enable=0 mid-event: the current event completes through TRAILER, then the FSM holds in IDLE.
- Pointer wrap: 2^L1ADDRWIDTH−1→0 for both pointers; occupancy arithmetic is modulo.
- busy = (state≠IDLE).

Test Plan:
- Reset held 3 cycles then released → dnBCST pixReset=1 through 1 cycle after release. All outputs otherwise 0. CBwrAddr counts 0,1,2… and wraps 511→0.
- Single L1AIn, chain presenting 3 hits, outReady=1 →
  - preLoad, then load one cycle later;
  - header L1rdAddr=0;
  - 3 data words, each followed by a chainRead pulse and a 1-cycle gap;
  - trailer hitCount=3, truncated=0;
  - L1rdAddr becomes 1.
- Event with 20 hits, MAXHITS=16 → 16 data words, then 4 flush chainReads with no output, then trailer {1,16}.
- 127 L1AIn with enable=0 → l1Full=1. 3 more L1AIn → no broadcast L1A, droppedL1A=3, L1wrAddr=127.
- outReady toggled 0/1 randomly during a 5-hit event → no word lost or duplicated, and outData is stable while stalled. Assert reset mid-SAMPLE → outValid=0 next cycle, IDLE, pointers 0.
